// File: rtl/b2m_vram_arbiter.sv
// Video RAM arbiter: video word fetches take priority over CPU byte accesses
// on the shared 16-bit SRAM; every access ends with a strobe-high turnaround cycle.
module b2m_vram_arbiter #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic        clk50,
   input  logic        reset_n,
   input  logic        vid_drq,
   input  logic [13:0] vid_addr,
   output logic [15:0] vid_data,
   output logic        vid_valid,
   output logic        vid_overrun,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   output logic [13:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_be_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_VRD, S_CRD, S_CWR, S_DONE} state_t;

   localparam logic [2:0] LAST_CNT = 3'(MEM_WAIT);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        vpend_q, vpend_d;
   logic [13:0] vpend_addr_q, vpend_addr_d;
   logic [13:0] vlast_addr_q, vlast_addr_d;
   logic        vlast_valid_q, vlast_valid_d;
   logic        vid_overrun_q, vid_overrun_d;
   logic [15:0] vid_data_q, vid_data_d;
   logic        vid_valid_q, vid_valid_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic [13:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]  mem_be_n_q, mem_be_n_d;
   logic        mem_oe_n_q, mem_oe_n_d;
   logic        mem_we_n_q, mem_we_n_d;
   logic        new_req;

   assign new_req = vid_drq && (!vlast_valid_q || (vid_addr != vlast_addr_q));

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 3'd0;
         vpend_q       <= 1'b0;
         vpend_addr_q  <= 14'd0;
         vlast_addr_q  <= 14'd0;
         vlast_valid_q <= 1'b0;
         vid_overrun_q <= 1'b0;
         vid_data_q    <= 16'd0;
         vid_valid_q   <= 1'b0;
         cpu_rdata_q   <= 8'd0;
         cpu_ack_q     <= 1'b0;
         mem_addr_q    <= 14'd0;
         mem_wdata_q   <= 16'd0;
         mem_be_n_q    <= 2'b11;
         mem_oe_n_q    <= 1'b1;
         mem_we_n_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         vpend_q       <= vpend_d;
         vpend_addr_q  <= vpend_addr_d;
         vlast_addr_q  <= vlast_addr_d;
         vlast_valid_q <= vlast_valid_d;
         vid_overrun_q <= vid_overrun_d;
         vid_data_q    <= vid_data_d;
         vid_valid_q   <= vid_valid_d;
         cpu_rdata_q   <= cpu_rdata_d;
         cpu_ack_q     <= cpu_ack_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_n_q    <= mem_be_n_d;
         mem_oe_n_q    <= mem_oe_n_d;
         mem_we_n_q    <= mem_we_n_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      vpend_d       = vpend_q;
      vpend_addr_d  = vpend_addr_q;
      vlast_addr_d  = vlast_addr_q;
      vlast_valid_d = vlast_valid_q;
      vid_overrun_d = vid_overrun_q;
      vid_data_d    = vid_data_q;
      vid_valid_d   = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      cpu_ack_d     = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_n_d    = mem_be_n_q;
      mem_oe_n_d    = mem_oe_n_q;
      mem_we_n_d    = mem_we_n_q;

      // Capture runs in every state; a still-pending request being replaced is an overrun.
      if (new_req) begin
         vpend_d       = 1'b1;
         vpend_addr_d  = vid_addr;
         vlast_addr_d  = vid_addr;
         vlast_valid_d = 1'b1;
         if (vpend_q) vid_overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // A request arriving this cycle is served directly, so video wins any tie.
            if (vpend_q || new_req) begin
               state_d    = S_VRD;
               cnt_d      = 3'd0;
               vpend_d    = 1'b0;
               mem_addr_d = new_req ? vid_addr : vpend_addr_q;
               mem_be_n_d = 2'b00;
               mem_oe_n_d = 1'b0;
            end else if (cpu_req) begin
               cnt_d      = 3'd0;
               mem_addr_d = cpu_addr[14:1];
               if (cpu_we) begin
                  state_d     = S_CWR;
                  mem_wdata_d = {cpu_wdata, cpu_wdata};
                  mem_be_n_d  = cpu_addr[0] ? 2'b01 : 2'b10;
                  mem_we_n_d  = 1'b0;
               end else begin
                  state_d    = S_CRD;
                  mem_be_n_d = 2'b00;
                  mem_oe_n_d = 1'b0;
               end
            end
         end
         S_VRD, S_CRD, S_CWR: begin
            if (cnt_q == LAST_CNT) begin
               state_d    = S_DONE;
               mem_oe_n_d = 1'b1;
               mem_we_n_d = 1'b1;
               if (state_q == S_VRD) begin
                  vid_data_d  = mem_rdata;
                  vid_valid_d = 1'b1;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (state_q == S_CRD)
                     cpu_rdata_d = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign vid_data    = vid_data_q;
   assign vid_valid   = vid_valid_q;
   assign vid_overrun = vid_overrun_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign cpu_ack     = cpu_ack_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be_n    = mem_be_n_q;
   assign mem_oe_n    = mem_oe_n_q;
   assign mem_we_n    = mem_we_n_q;

endmodule
